// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback block.
// Entry layout is used by the load FIFO and the arbitration logic.
package regfile_pkg;

  localparam int NREG       = 16;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int REG_IDX_W  = $clog2(NREG);

  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } entry_t;

  function automatic logic addr_ok(
    input logic [REG_ADDR_W-1:0] a
  );
    return a < REG_ADDR_W'(NREG);
  endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Writeback bus: ALU result, load handshake, register-file write port
// and the hazard/status outputs seen by issue.
interface regfile_writeback_if
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
);

  logic                    alu_valid;
  logic [REG_ADDR_W-1:0]   alu_addr;
  logic [DATA_W-1:0]       alu_data;
  logic                    ld_valid;
  logic                    ld_ready;
  logic [REG_ADDR_W-1:0]   ld_addr;
  logic [DATA_W-1:0]       ld_data;
  logic                    RegWr;
  logic [REG_ADDR_W-1:0]   Waddr;
  logic [DATA_W-1:0]       Writedata;
  logic [NREG-1:0]         pend_mask;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    addr_err;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output ld_valid, ld_addr, ld_data,
    input  ld_ready,
    input  RegWr, Waddr, Writedata,
    input  pend_mask, fifo_count, addr_err
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  ld_valid, ld_addr, ld_data,
    output ld_ready,
    output RegWr, Waddr, Writedata,
    output pend_mask, fifo_count, addr_err
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular load buffer with per-entry live bits, squash by address
// and a live-address mask for hazard checks.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  entry_t                push_entry,
  input  logic                  pop,
  input  logic                  squash_en,
  input  logic [REG_ADDR_W-1:0] squash_addr,
  output entry_t                head,
  output logic [$clog2(DEPTH):0] count,
  output logic [NREG-1:0]       pend_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  // Squash older entries first, then pop, then the new entry lands.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
    if (squash_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_q[i].addr == squash_addr) begin
          mem_d[i].live = 1'b0;
        end
      end
    end
    if (pop) begin
      mem_d[head_q].live = 1'b0;
      head_d = head_q + PW'(1);
    end
    if (push) begin
      mem_d[tail_q] = push_entry;
      tail_d = tail_q + PW'(1);
    end
  end

  // Buffer state; reset drops every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Popped slots have live cleared, so live alone marks pending writes.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_q[i].live) begin
        pend_mask[mem_q[i].addr[REG_IDX_W-1:0]] = 1'b1;
      end
    end
  end

  assign head  = mem_q[head_q];
  assign count = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write port: ALU results win, loads drain from a FIFO
// when the ALU is idle, stale loads are squashed on WAW.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  regfile_writeback_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                  alu_ok;
  logic                  ld_ok;
  logic                  ld_ready;
  logic                  push;
  logic                  pop;
  logic                  squash_en;
  entry_t                head;
  entry_t                push_entry;
  logic [CW-1:0]         count;
  logic [NREG-1:0]       pend_mask;

  logic                  regwr_q, regwr_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  addr_err_q, addr_err_d;

  assign alu_ok    = addr_ok(bus.alu_addr);
  assign ld_ok     = addr_ok(bus.ld_addr);
  assign ld_ready  = count < CW'(DEPTH);
  assign push      = bus.ld_valid && ld_ready;
  assign pop       = !bus.alu_valid && (count != '0);
  assign squash_en = bus.alu_valid && alu_ok;

  assign push_entry = '{live: ld_ok,
                        addr: bus.ld_addr,
                        data: bus.ld_data};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (CLK),
    .rst_n       (RESET),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .squash_en   (squash_en),
    .squash_addr (bus.alu_addr),
    .head        (head),
    .count       (count),
    .pend_mask   (pend_mask)
  );

  // Pick the write for this edge; idle cycles hold address and data.
  always_comb begin
    regwr_d    = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    addr_err_d = (bus.alu_valid && !alu_ok) || (push && !ld_ok);
    unique case (1'b1)
      bus.alu_valid && alu_ok: begin
        regwr_d = 1'b1;
        waddr_d = bus.alu_addr;
        wdata_d = bus.alu_data;
      end
      pop && head.live: begin
        regwr_d = 1'b1;
        waddr_d = head.addr;
        wdata_d = head.data;
      end
      default: ;
    endcase
  end

  // Registered write port and error pulse.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      regwr_q    <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      addr_err_q <= 1'b0;
    end else begin
      regwr_q    <= regwr_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.ld_ready   = ld_ready;
  assign bus.RegWr      = regwr_q;
  assign bus.Waddr      = waddr_q;
  assign bus.Writedata  = wdata_q;
  assign bus.pend_mask  = pend_mask;
  assign bus.fifo_count = count;
  assign bus.addr_err   = addr_err_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with a queue-based model
// checked every cycle plus literal expectations per scenario.
module tb_regfile_writeback;
  import regfile_pkg::*;

  localparam int DEPTH = 4;

  logic CLK;
  logic RESET;
  int   n_chk;
  int   n_err;

  regfile_writeback_if #(.DEPTH(DEPTH)) b ();

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the FIFO as a queue of pending loads.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          live;
  } ment_t;

  ment_t       mq[$];
  logic        e_wr;
  logic [4:0]  e_wa;
  logic [31:0] e_wd;
  logic        e_err;

  always @(posedge CLK or negedge RESET) begin : model
    bit    psh;
    ment_t e;
    if (!RESET) begin
      mq.delete();
      e_wr  = 1'b0;
      e_wa  = '0;
      e_wd  = '0;
      e_err = 1'b0;
    end else begin
      psh   = b.ld_valid && (mq.size() < DEPTH);
      e_err = (b.alu_valid && int'(b.alu_addr) >= NREG) ||
              (psh && int'(b.ld_addr) >= NREG);
      e_wr  = 1'b0;
      if (b.alu_valid) begin
        if (int'(b.alu_addr) < NREG) begin
          e_wr = 1'b1;
          e_wa = b.alu_addr;
          e_wd = b.alu_data;
          foreach (mq[i]) if (mq[i].a == b.alu_addr) mq[i].live = 0;
        end
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        if (e.live) begin
          e_wr = 1'b1;
          e_wa = e.a;
          e_wd = e.d;
        end
      end
      if (psh) begin
        e.a = b.ld_addr;
        e.d = b.ld_data;
        e.live = int'(b.ld_addr) < NREG;
        mq.push_back(e);
      end
    end
  end

  function automatic logic [15:0] m_pend();
    logic [15:0] m = '0;
    foreach (mq[i]) if (mq[i].live) m[mq[i].a[3:0]] = 1'b1;
    return m;
  endfunction

  // Compare process, away from the active edge.
  always @(negedge CLK) begin
    if (RESET) begin
      chk("m_regwr", 32'(b.RegWr), 32'(e_wr));
      chk("m_waddr", 32'(b.Waddr), 32'(e_wa));
      chk("m_wdata", b.Writedata, e_wd);
      chk("m_err", 32'(b.addr_err), 32'(e_err));
      chk("m_count", 32'(b.fifo_count), 32'(mq.size()));
      chk("m_pend", 32'(b.pend_mask), 32'(m_pend()));
      chk("m_ready", 32'(b.ld_ready), 32'(mq.size() < DEPTH));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drv(input logic av, input logic [4:0] aa,
                     input logic [31:0] ad, input logic lv,
                     input logic [4:0] la, input logic [31:0] ld);
    b.alu_valid = av;
    b.alu_addr  = aa;
    b.alu_data  = ad;
    b.ld_valid  = lv;
    b.ld_addr   = la;
    b.ld_data   = ld;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic expo(input string t, input logic wr,
                      input logic [4:0] wa, input logic [31:0] wd,
                      input int cnt, input logic [15:0] pm);
    chk({t, "_wr"}, 32'(b.RegWr), 32'(wr));
    chk({t, "_wa"}, 32'(b.Waddr), 32'(wa));
    chk({t, "_wd"}, b.Writedata, wd);
    chk({t, "_cnt"}, 32'(b.fifo_count), 32'(cnt));
    chk({t, "_pm"}, 32'(b.pend_mask), 32'(pm));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    RESET = 1'b0;
    idle();
    tick();
    tick();
    RESET = 1'b1;
    expo("rst", 1'b0, 5'd0, 32'd0, 0, 16'h0);
    chk("rst_ready", 32'(b.ld_ready), 32'd1);
    chk("rst_err", 32'(b.addr_err), 32'd0);

    // ALU only
    drv(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    tick();
    expo("alu1", 1'b1, 5'd3, 32'hDEADBEEF, 0, 16'h0);
    idle();
    tick();
    expo("alu2", 1'b0, 5'd3, 32'hDEADBEEF, 0, 16'h0);

    // Load latency
    drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    tick();
    expo("ld1", 1'b0, 5'd3, 32'hDEADBEEF, 1, 16'h0020);
    idle();
    tick();
    expo("ld2", 1'b1, 5'd5, 32'h1234, 0, 16'h0);

    // Fill under ALU pressure, then backpressure
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 5'd1, 32'h100 + i, 1'b1, 5'(8 + i), 32'h200 + i);
      tick();
    end
    expo("fill", 1'b1, 5'd1, 32'h103, 4, 16'h0F00);
    chk("full_ready", 32'(b.ld_ready), 32'd0);
    drv(1'b1, 5'd1, 32'h104, 1'b1, 5'd12, 32'h999);
    tick();
    expo("bp", 1'b1, 5'd1, 32'h104, 4, 16'h0F00);
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      expo("drain", 1'b1, 5'(8 + i), 32'h200 + i, 3 - i,
           16'h0F00 & ~((16'h0200 << i) - 16'h0100));
      chk("drain_ready", 32'(b.ld_ready), 32'd1);
    end

    // WAW squash and same-edge keep
    drv(1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'hA);
    tick();
    expo("waw1", 1'b1, 5'd1, 32'h11, 1, 16'h0080);
    drv(1'b1, 5'd1, 32'h12, 1'b1, 5'd2, 32'hB);
    tick();
    expo("waw2", 1'b1, 5'd1, 32'h12, 2, 16'h0084);
    drv(1'b1, 5'd7, 32'hC, 1'b0, 5'd0, 32'd0);
    tick();
    expo("waw3", 1'b1, 5'd7, 32'hC, 2, 16'h0004);
    drv(1'b1, 5'd7, 32'hE, 1'b1, 5'd7, 32'hD);
    tick();
    expo("waw4", 1'b1, 5'd7, 32'hE, 3, 16'h0084);
    idle();
    tick();
    expo("waw5", 1'b0, 5'd7, 32'hE, 2, 16'h0084);
    tick();
    expo("waw6", 1'b1, 5'd2, 32'hB, 1, 16'h0080);
    tick();
    expo("waw7", 1'b1, 5'd7, 32'hD, 0, 16'h0000);

    // Illegal addresses
    drv(1'b1, 5'h12, 32'h55, 1'b0, 5'd0, 32'd0);
    tick();
    expo("ill_alu", 1'b0, 5'd7, 32'hD, 0, 16'h0);
    chk("ill_alu_err", 32'(b.addr_err), 32'd1);
    idle();
    tick();
    chk("ill_alu_err0", 32'(b.addr_err), 32'd0);
    drv(1'b0, 5'd0, 32'd0, 1'b1, 5'h1F, 32'h77);
    tick();
    expo("ill_ld", 1'b0, 5'd7, 32'hD, 1, 16'h0);
    chk("ill_ld_err", 32'(b.addr_err), 32'd1);
    idle();
    tick();
    expo("ill_ld2", 1'b0, 5'd7, 32'hD, 0, 16'h0);
    chk("ill_ld_err0", 32'(b.addr_err), 32'd0);
    drv(1'b1, 5'h12, 32'h1, 1'b1, 5'h1F, 32'h2);
    tick();
    chk("ill_both_err", 32'(b.addr_err), 32'd1);
    idle();
    tick();
    expo("ill_both", 1'b0, 5'd7, 32'hD, 0, 16'h0);
    chk("ill_both_err0", 32'(b.addr_err), 32'd0);

    // Reset mid-drain
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 5'd1, 32'h300 + i, 1'b1, 5'(3 + i), 32'h400 + i);
      tick();
    end
    idle();
    tick();
    expo("mid", 1'b1, 5'd3, 32'h400, 2, 16'h0030);
    #2;
    RESET = 1'b0;
    #1;
    expo("arst", 1'b0, 5'd0, 32'd0, 0, 16'h0);
    #3;
    RESET = 1'b1;
    tick();
    expo("post1", 1'b0, 5'd0, 32'd0, 0, 16'h0);
    tick();
    expo("post2", 1'b0, 5'd0, 32'd0, 0, 16'h0);
    chk("post_ready", 32'(b.ld_ready), 32'd1);

    @(negedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Owns the single write port of the 16 x 32-bit general-purpose register file and drives RegWr/Waddr/Writedata.
- Arbitrates two result sources:
  - ALU results: fixed priority, never stalled.
  - Load results: valid/ready handshake, buffered in a small FIFO.
- Squashes buffered load writes that a newer ALU write makes stale (WAW).
- Exports a per-register pending-write mask for issue-stage hazard checks.

Parameters:
- DEPTH, 4, load FIFO entries (power of two, 2..16)
- NREG, 16, architectural registers; addresses >= NREG are illegal

Ports:
- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle; always accepted
- alu_addr  in  5  ALU destination register
- alu_data  in  32  ALU result
- ld_valid  in  1  load result offered
- ld_ready  out  1  FIFO can accept; transfer when ld_valid && ld_ready at posedge
- ld_addr  in  5  load destination register
- ld_data  in  32  load data
- RegWr  out  1  register-file write enable (registered)
- Waddr  out  5  register-file write address (registered)
- Writedata  out  32  register-file write data (registered)
- pend_mask  out  16  bit r = 1 while a live buffered load targets register r
- fifo_count  out  $clog2(DEPTH)+1  occupied entries, live and squashed
- addr_err  out  1  one-cycle pulse when an illegal address is dropped

Behaviour:
- Reset (RESET=0, asynchronous):
  - RegWr=0, Waddr=0, Writedata=0, addr_err=0.
  - FIFO emptied and all entry-live bits cleared, so fifo_count=0 and pend_mask=0.
  - ld_ready=1 once reset is released.
  - Reset mid-operation discards buffered loads; no partial write is issued.
- Outputs are registered at posedge. The register file writes on negedge, so data is stable half a cycle before use.
- ALU path:
  - alu_valid sampled at edge k gives RegWr=1, Waddr=alu_addr, Writedata=alu_data after edge k (1-cycle latency).
- Load path:
  - Push at edge k when ld_valid && ld_ready; the entry is stored with live=1.
  - Earliest write is after edge k+1, if the entry is head and alu_valid=0 at edge k+1 (2-cycle latency).
- Pop rule, evaluated at each edge with alu_valid=0 and FIFO non-empty:
  - Head live: pop and issue the write (RegWr=1).
  - Head squashed: pop with no write (RegWr=0). Exactly one entry pops per cycle.
- With alu_valid=1, no pop occurs; the ALU write wins.
- When no write is issued, RegWr=0. Waddr and Writedata hold their previous values.
- ld_ready = (fifo_count < DEPTH), computed from registered state. A pop in the same cycle does not free space for a push when full.
- Simultaneous push and pop are allowed (count unchanged). Pointers wrap modulo DEPTH.
- WAW squash:
  - An accepted ALU write to register r at edge k clears live on every FIFO entry with addr == r present before edge k.
  - A load pushed at the same edge k is younger and is NOT squashed.
- pend_mask[r] = OR over live entries with addr==r, updated the same edge as push, pop or squash.
- Illegal address (addr[4]=1):
  - ALU case: no write issued; addr_err=1 for one cycle; no squash occurs.
  - Load case: the load is accepted but stored with live=0, and addr_err pulses one cycle after the push.
  - If both sources are illegal in one cycle, addr_err is still a single pulse.
- ALU priority can starve loads indefinitely. Upstream guarantees ALU idle cycles; no internal starvation counter.

Decomposition:
- Shared package regfile_pkg:
  - NREG, REG_ADDR_W=5, DATA_W=32.
  - Entry struct {live, addr[4:0], data[31:0]}.
- Sub-module wb_fifo: circular buffer with head/tail pointers, count, per-entry live bits, parallel squash-by-address input, and live-address outputs for pend_mask.
- Top level holds arbitration, output registers and illegal-address detection.

Test Plan:
- Reset then ALU only:
  - Stimulus: alu_valid=1, addr=3, data=0xDEADBEEF at edge 1.
  - Required: RegWr=1, Waddr=3, Writedata=0xDEADBEEF after edge 1; RegWr=0 after edge 2 with alu_valid=0.
- Load latency:
  - Stimulus: push addr=5, data=0x1234 at edge 1, ALU idle.
  - Required: pend_mask=0x0020 after edge 1; RegWr=1, Waddr=5 after edge 2; pend_mask=0 after edge 2.
- Fill and backpressure:
  - Stimulus: hold alu_valid=1 (addr 1); push 4 loads.
  - Required: fifo_count=4 and ld_ready=0; a 5th ld_valid is not accepted.
  - Then drop alu_valid: loads drain in push order, one per cycle, with ld_ready=1 after the first pop.
- WAW squash:
  - Stimulus: buffer loads to r7 (0xA) and r2 (0xB) under ALU activity; then ALU writes r7=0xC.
  - Required: pend_mask bit7 clears; drain produces one idle pop (RegWr=0) and then the r2 write only.
  - Also: a same-edge load to r7 is kept.
- Illegal address:
  - ALU addr=0x12 → no write, addr_err pulse.
  - Load addr=0x1F → accepted, never written, pend_mask unaffected.
- Reset mid-drain:
  - Stimulus: 3 buffered loads, assert RESET=0 asynchronously between edges.
  - Required: RegWr=0, fifo_count=0, pend_mask=0 immediately; no write after release.
